// File: rtl/avl_burst_mem_slave.sv
// Avalon-MM burst slave backed by on-chip RAM, standing in for a DDR3 controller.
// Optional `AVL_READY_STALL_EN adds LFSR-driven avl_ready stalls in IDLE/WRITE.
module avl_burst_mem_slave #(
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned RD_LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    output logic         calib_done,
    output logic         avl_ready,
    input  logic         avl_burstbegin,
    input  logic [24:0]  avl_address,
    input  logic [7:0]   avl_size,
    input  logic         avl_read_req,
    input  logic         avl_write_req,
    input  logic [127:0] avl_wdata,
    input  logic [15:0]  avl_be,
    output logic         avl_rdata_valid,
    output logic [127:0] avl_rdata,
    output logic         proto_err
);
    localparam int unsigned DEPTH = 1 << MEM_AW;

    typedef enum logic [1:0] {INIT, IDLE, WRITE, READ} state_t;

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   init_q, init_d;
    logic [MEM_AW-1:0]   base_q, base_d;
    logic [7:0]          size_q, size_d;
    logic [7:0]          off_q, off_d;
    logic [7:0]          ret_q, ret_d;
    logic                calib_q, calib_d;
    logic                perr_q, perr_d;

    logic [127:0]        mem [DEPTH];
    logic [127:0]        rd_q;
    logic [RD_LATENCY-1:0] pv_q;
    logic [127:0]        pd_q [1:RD_LATENCY-1];

    logic                we;
    logic [MEM_AW-1:0]   waddr;
    logic [127:0]        wdata;
    logic [15:0]         wbe;
    logic                rd_issue;
    logic [MEM_AW-1:0]   off_addr;
    logic                stall;
    logic                ready;
    logic                unused_addr_hi;

    assign off_addr       = base_q + MEM_AW'(off_q);
    assign unused_addr_hi = ^avl_address[24:MEM_AW];

`ifdef AVL_READY_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) lfsr_q <= 16'hACE1;
        else          lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign stall = lfsr_q[0] & lfsr_q[3];
`else
    assign stall = 1'b0;
`endif

    assign ready = ((state_q == IDLE) || (state_q == WRITE)) && !stall;

    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        base_d   = base_q;
        size_d   = size_q;
        off_d    = off_q;
        ret_d    = ret_q;
        calib_d  = calib_q;
        perr_d   = perr_q;
        we       = 1'b0;
        waddr    = off_addr;
        wdata    = avl_wdata;
        wbe      = avl_be;
        rd_issue = 1'b0;
        case (state_q)
            INIT: begin
                we     = 1'b1;
                waddr  = init_q;
                wdata  = '0;
                wbe    = '1;
                init_d = init_q + 1'b1;
                if (init_q == '1) begin
                    state_d = IDLE;
                    calib_d = 1'b1;
                end
            end
            IDLE: begin
                if (ready) begin
                    if (avl_burstbegin) begin
                        if ((avl_write_req && avl_read_req) ||
                            ((avl_write_req || avl_read_req) && avl_size == 8'd0)) begin
                            perr_d = 1'b1;
                        end else if (avl_write_req) begin
                            // Beat 0 lands at accept; the burst continues from offset 1.
                            we     = 1'b1;
                            waddr  = avl_address[MEM_AW-1:0];
                            base_d = avl_address[MEM_AW-1:0];
                            size_d = avl_size;
                            off_d  = 8'd1;
                            if (avl_size != 8'd1) state_d = WRITE;
                        end else if (avl_read_req) begin
                            base_d  = avl_address[MEM_AW-1:0];
                            size_d  = avl_size;
                            off_d   = '0;
                            ret_d   = '0;
                            state_d = READ;
                        end
                    end else if (avl_write_req || avl_read_req) begin
                        perr_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (ready) begin
                    if (avl_burstbegin || avl_read_req) perr_d = 1'b1;
                    if (avl_write_req) begin
                        we    = 1'b1;
                        off_d = off_q + 8'd1;
                        if (off_q == size_q - 8'd1) state_d = IDLE;
                    end
                end
            end
            READ: begin
                if (off_q != size_q) begin
                    rd_issue = 1'b1;
                    off_d    = off_q + 8'd1;
                end
                // Leave only once the final beat has been presented on the bus.
                if (pv_q[RD_LATENCY-1]) begin
                    ret_d = ret_q + 8'd1;
                    if (ret_q == size_q - 8'd1) state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= INIT;
            init_q  <= '0;
            base_q  <= '0;
            size_q  <= '0;
            off_q   <= '0;
            ret_q   <= '0;
            calib_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            base_q  <= base_d;
            size_q  <= size_d;
            off_q   <= off_d;
            ret_q   <= ret_d;
            calib_q <= calib_d;
            perr_q  <= perr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && reset_n) begin
            for (int unsigned b = 0; b < 16; b++) begin
                if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (rd_issue) rd_q <= mem[off_addr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pv_q <= '0;
            for (int unsigned i = 1; i < RD_LATENCY; i++) pd_q[i] <= '0;
        end else begin
            pv_q    <= {pv_q[RD_LATENCY-2:0], rd_issue};
            pd_q[1] <= rd_q;
            for (int unsigned i = 2; i < RD_LATENCY; i++) pd_q[i] <= pd_q[i-1];
        end
    end

    assign calib_done      = calib_q;
    assign avl_ready       = ready;
    assign avl_rdata_valid = pv_q[RD_LATENCY-1];
    assign avl_rdata       = pd_q[RD_LATENCY-1];
    assign proto_err       = perr_q;

endmodule

// File: doc/avl_burst_mem_slave.md
# avl_burst_mem_slave

Synthesizable Avalon-MM burst responder backed by on-chip RAM: the slave-side counterpart to the acoustics DDR3 burst master. Accepts burst writes and burst reads on the same avl_* handshake the DDR3 controller presents, and signals calibration complete after clearing memory. Used as a drop-in DDR3 stand-in for bring-up, simulation and loopback checks of the capture path.

## Interface
- MEM_AW, 10: internal RAM address width, 2^MEM_AW 128-bit words
- RD_LATENCY, 4: cycles from read-burst accept to first avl_rdata_valid; legal range 2..15
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous and active-low
- calib_done  out  1  memory cleared and ready for traffic
- avl_ready  out  1  slave can accept a command or write beat
- avl_burstbegin  in  1  first beat of a burst command
- avl_address  in  25  word address of burst start; bits [MEM_AW-1:0] used
- avl_size  in  8  beats in the burst, 1..255
- avl_read_req  in  1  read command
- avl_write_req  in  1  write command or beat
- avl_wdata  in  128  write data
- avl_be  in  16  byte enables, bit i covers wdata[8i+7:8i]
- avl_rdata_valid  out  1  avl_rdata holds a read beat
- avl_rdata  out  128  read data
- proto_err  out  1  sticky protocol-violation flag

## Operation
- States: INIT, IDLE, WRITE, READ.
- INIT: entered on reset; writes zero to words 0..2^MEM_AW-1, one per cycle; then calib_done=1, go IDLE. calib_done stays 1 until next reset.
- IDLE: avl_ready=1. Command accepted when avl_ready and avl_burstbegin sampled high:
  - write_req only: capture base=address[MEM_AW-1:0], beats=size, write beat 0 at base, go WRITE (or stay IDLE if size==1).
  - read_req only: capture base and size, go READ.
  - both reqs, or size==0: proto_err<=1, command dropped, stay IDLE.
  - write_req or read_req without burstbegin: proto_err<=1, ignored.
- WRITE: avl_ready=1; each cycle with write_req high is a beat, written to (base+n) mod 2^MEM_AW, only bytes with avl_be set modified. After beat size-1, go IDLE. burstbegin or read_req in WRITE: proto_err<=1, beat still counted only if write_req high.
- READ: avl_ready=0; RAM read issued for words base..base+size-1 (mod 2^MEM_AW), one per cycle, through a RD_LATENCY-deep pipe; returns exactly size beats on consecutive cycles; go IDLE after final beat leaves the pipe. Inputs ignored in READ (no proto_err, since ready is low).
- Address arithmetic: beat offset counter 8 bits; address sum truncated to MEM_AW bits (wrap, no error).
- Write-then-read of same address returns the new data (write completes before READ accept).

## Timing
- Reset values: calib_done=0, avl_ready=0, avl_rdata_valid=0, avl_rdata=0, proto_err=0.
- INIT lasts 2^MEM_AW cycles after reset_n rises; calib_done and avl_ready rise on the same edge.
- Read accepted at edge T: avl_ready low from T+1; avl_rdata_valid high T+RD_LATENCY through T+RD_LATENCY+size-1; avl_ready high again at T+RD_LATENCY+size.
- Write beat consumed on every edge where avl_ready and avl_write_req are high; data visible to a read command accepted the following cycle.
- reset_n low at any time: burst aborted, read pipe flushed (no further rdata_valid), state INIT on next edge, RAM re-cleared.

## Configuration
- AVL_READY_STALL_EN: when defined, a 16-bit LFSR (seed 0xACE1, advances every cycle) deasserts avl_ready in WRITE and IDLE whenever its bit 0 and bit 3 are both 1; unaccepted beats/commands are not consumed and the master must hold them. Undefined: avl_ready follows the rules above with no stalls. Read-return timing is unaffected either way.

## Test plan
- Reset release, MEM_AW=4 -> calib_done and avl_ready rise exactly 16 cycles later; any read returns 0.
- Write burst address 0x3, size 16, data = beat index, be=0xFFFF -> read burst address 0x3 size 16 returns 0..15 in order, valid starting 4 cycles after accept.
- MEM_AW=4, write size 4 at address 0xE -> words 0xE,0xF,0x0,0x1 written; read at 0x0 size 2 returns beats 2,3.
- Write 0xFF..FF to word 5, then size-1 write of 0 with be=0x0001 -> read returns 0xFF..FF00.
- burstbegin with read_req and write_req both high, and a size==0 command -> proto_err=1, memory unchanged, avl_ready stays 1.
- reset_n pulled low at beat 2 of a size-8 read -> no further avl_rdata_valid, calib_done=0 next cycle, re-init completes normally.
